// File: rtl/popcnt_share_pkg.sv
// Shared types and helpers for the count-ones engine share controller.
package popcnt_share_pkg;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned R_DEF = 4;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_ISSUE     = 5'b00010,
    S_WAIT_DONE = 5'b00100,
    S_RESPOND   = 5'b01000,
    S_RELEASE   = 5'b10000
  } state_e;

  function automatic int unsigned id_w(input int unsigned r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/popcnt_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter
  import popcnt_share_pkg::*;
#(
  parameter int unsigned R   = R_DEF,
  parameter int unsigned IDW = id_w(R)
) (
  input  logic [R-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [R-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o
);

  int unsigned idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    idx      = 0;
    // Scan from farthest to nearest so the nearest hit overwrites earlier ones.
    for (int k = int'(R) - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % R;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/popcnt_share_ctrl.sv
// Round-robin share of one count-ones engine among R requesters.
// Optional engine watchdog enabled by defining POPCNT_SHARE_TIMEOUT_EN.
module popcnt_share_ctrl
  import popcnt_share_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned R     = R_DEF,
  parameter int unsigned TMO_W = 5,
  localparam int unsigned IDW  = id_w(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] req_data,
  output logic [R-1:0]   ack,
  output logic [N-1:0]   rsp_result,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_err,
  output logic           busy,
  output logic           eng_start,
  output logic [N-1:0]   eng_a,
  input  logic           eng_done,
  input  logic [N-1:0]   eng_result
);

  if (R < 2 || R > 16 || TMO_W < 2) begin : g_bad_cfg
    $error("popcnt_share_ctrl: unsupported R or TMO_W");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [R-1:0]   ack_q, ack_d;
  logic [N-1:0]   rsp_result_q, rsp_result_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [R-1:0]   arb_gnt;
  logic [IDW-1:0] arb_id;

`ifdef POPCNT_SHARE_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    gnt_id_d     = gnt_id_q;
    ptr_d        = ptr_q;
    ack_d        = '0;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
`ifdef POPCNT_SHARE_TIMEOUT_EN
    tmo_d        = tmo_q;
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A still-high done means the engine has not left FINISH yet.
        if ((|arb_gnt) && !eng_done) begin
          a_d      = req_data[arb_id*N +: N];
          gnt_id_d = arb_id;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef POPCNT_SHARE_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (eng_done) begin
          rsp_result_d     = eng_result;
          rsp_id_d         = gnt_id_q;
          ack_d[gnt_id_q]  = 1'b1;
          state_d          = S_RESPOND;
`ifdef POPCNT_SHARE_TIMEOUT_EN
          rsp_err_d        = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          rsp_result_d     = '0;
          rsp_id_d         = gnt_id_q;
          ack_d[gnt_id_q]  = 1'b1;
          rsp_err_d        = 1'b1;
          state_d          = S_RESPOND;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_RESPOND: begin
        ptr_d   = (gnt_id_q == IDW'(R - 1)) ? '0 : gnt_id_q + 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!eng_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: synchronous reset; state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      gnt_id_q     <= '0;
      ptr_q        <= '0;
      ack_q        <= '0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
`ifdef POPCNT_SHARE_TIMEOUT_EN
      tmo_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      gnt_id_q     <= gnt_id_d;
      ptr_q        <= ptr_d;
      ack_q        <= ack_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
`ifdef POPCNT_SHARE_TIMEOUT_EN
      tmo_q        <= tmo_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != S_IDLE);
  assign eng_start  = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
  assign eng_a      = a_q;
`ifdef POPCNT_SHARE_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_popcnt_share_ctrl.sv
// Directed bench for popcnt_share_ctrl with a behavioural count-ones engine.
module tb_popcnt_share_ctrl;

  localparam int N       = 8;
  localparam int R       = 4;
  localparam int IDW     = 2;
  localparam int ENG_LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   ack;
  logic [N-1:0]   rsp_result;
  logic [IDW-1:0] rsp_id;
  logic           rsp_err;
  logic           busy;
  logic           eng_start;
  logic [N-1:0]   eng_a;
  logic           eng_done;
  logic [N-1:0]   eng_result;
  bit             eng_hang;

  int n_cmp  = 0;
  int n_fail = 0;

  popcnt_share_ctrl #(.N(N), .R(R), .TMO_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  always #5 clk = ~clk;

  // Engine model: IDLE -> BUSY (ENG_LAT cycles) -> FINISH (done held until start drops).
  logic [1:0] eng_st;
  int         eng_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_st     <= 2'd0;
      eng_cnt    <= 0;
      eng_done   <= 1'b0;
      eng_result <= '0;
    end else begin
      case (eng_st)
        2'd0: if (eng_start) begin eng_st <= 2'd1; eng_cnt <= 0; end
        2'd1: begin
          if (!eng_start) eng_st <= 2'd0;
          else if (!eng_hang) begin
            if (eng_cnt == ENG_LAT - 1) begin
              eng_done   <= 1'b1;
              eng_result <= N'($countones(eng_a));
              eng_st     <= 2'd2;
            end else eng_cnt <= eng_cnt + 1;
          end
        end
        default: if (!eng_start) begin eng_done <= 1'b0; eng_st <= 2'd0; end
      endcase
    end
  end

  // Protocol monitors, compared at the end of the run.
  int         mon_multi_hot = 0;
  int         mon_long_ack  = 0;
  int         mon_early_gnt = 0;
  int         mon_err_acks  = 0;
  logic [R-1:0] ack_prev   = '0;
  logic         start_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ($countones(ack) > 1) mon_multi_hot++;
      if (ack != 0 && ack_prev != 0) mon_long_ack++;
      if (eng_start && !start_prev && eng_done) mon_early_gnt++;
      if (ack != 0 && rsp_err) mon_err_acks++;
    end
    ack_prev   = ack;
    start_prev = eng_start;
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    eng_hang = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int budget, output bit ok, output logic [R-1:0] a,
                          output logic [N-1:0] res, output logic [IDW-1:0] id, output logic err);
    ok = 1'b0; a = '0; res = '0; id = '0; err = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        ok = 1'b1; a = ack; res = rsp_result; id = rsp_id; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_eng_start got=%b exp=0", eng_start); end
    n_cmp++; if (eng_a !== 8'h00) begin n_fail++; $display("FAIL reset_eng_a got=%h exp=00", eng_a); end
    n_cmp++; if (rsp_result !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_result got=%h exp=00", rsp_result); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
  endtask

  task automatic test_single();
    bit ok; logic [R-1:0] a; logic [N-1:0] res; logic [IDW-1:0] id; logic err;
    req_data[7:0] = 8'hB5;
    req = 4'b0001;
    wait_ack(100, ok, a, res, id, err);
    req = '0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_ack_timeout got=none exp=ack"); end
    n_cmp++; if (a !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", a); end
    n_cmp++; if (res !== 8'd5) begin n_fail++; $display("FAIL single_result got=%0d exp=5", res); end
    n_cmp++; if (id !== 2'd0) begin n_fail++; $display("FAIL single_id got=%0d exp=0", id); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b exp=0", err); end
    @(negedge clk);
    n_cmp++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_busy_drop got=busy exp=idle"); end
    n_cmp++; if (eng_done !== 1'b0) begin n_fail++; $display("FAIL single_done_at_idle got=%b exp=0", eng_done); end
  endtask

  task automatic test_all4();
    bit ok; logic [R-1:0] a; logic [N-1:0] res; logic [IDW-1:0] id; logic err;
    logic [N-1:0] exp_res [4] = '{8'd0, 8'd8, 8'd4, 8'd1};
    do_reset();
    req_data = {8'h80, 8'h0F, 8'hFF, 8'h00};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(100, ok, a, res, id, err);
      req = req & ~a;
      n_cmp++; if (!ok || id !== IDW'(i)) begin n_fail++; $display("FAIL all4_id[%0d] got=%0d exp=%0d", i, id, i); end
      n_cmp++; if (a !== (4'b0001 << i)) begin n_fail++; $display("FAIL all4_ack[%0d] got=%b exp=%b", i, a, 4'b0001 << i); end
      n_cmp++; if (res !== exp_res[i]) begin n_fail++; $display("FAIL all4_result[%0d] got=%0d exp=%0d", i, res, exp_res[i]); end
      @(negedge clk);
      n_cmp++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL all4_pulse[%0d] got=%b exp=0000", i, ack); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [R-1:0] a; logic [N-1:0] res; logic [IDW-1:0] id; logic err;
    do_reset();
    req_data[7:0]  = 8'h01;
    req_data[15:8] = 8'h03;
    req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      wait_ack(100, ok, a, res, id, err);
      if (i == 7) req = '0;
      n_cmp++; if (!ok || id !== IDW'(i % 2)) begin n_fail++; $display("FAIL alt_id[%0d] got=%0d exp=%0d", i, id, i % 2); end
      n_cmp++; if (res !== ((i % 2) ? 8'd2 : 8'd1)) begin n_fail++; $display("FAIL alt_result[%0d] got=%0d exp=%0d", i, res, (i % 2) ? 2 : 1); end
    end
    wait_idle(ok);
  endtask

  task automatic test_withdraw();
    bit ok; logic [R-1:0] a; logic [N-1:0] res; logic [IDW-1:0] id; logic err;
    int stray;
    do_reset();
    req_data[7:0]  = 8'h03;
    req_data[15:8] = 8'hFF;
    req = 4'b0001;
    for (int i = 0; i < 10 && busy !== 1'b1; i++) @(negedge clk);
    req_data[7:0] = 8'hFF;
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    wait_ack(100, ok, a, res, id, err);
    req = '0;
    n_cmp++; if (!ok || a !== 4'b0001) begin n_fail++; $display("FAIL wd_ack got=%b exp=0001", a); end
    n_cmp++; if (res !== 8'd2) begin n_fail++; $display("FAIL wd_latched_operand got=%0d exp=2", res); end
    stray = 0;
    repeat (30) begin @(negedge clk); if (ack !== 4'b0000) stray++; end
    n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL wd_withdrawn_ack got=%0d exp=0", stray); end
    req = 4'b0011;
    wait_ack(100, ok, a, res, id, err);
    req = '0;
    n_cmp++; if (!ok || id !== 2'd1) begin n_fail++; $display("FAIL wd_pointer got=%0d exp=1", id); end
    n_cmp++; if (res !== 8'd8) begin n_fail++; $display("FAIL wd_result got=%0d exp=8", res); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok; logic [R-1:0] a; logic [N-1:0] res; logic [IDW-1:0] id; logic err;
    int stray;
    do_reset();
    eng_hang = 1'b1;
    req_data[7:0] = 8'h77;
    req = 4'b0001;
    for (int i = 0; i < 10 && eng_start !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup got=%b exp=1", eng_start); end
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    n_cmp++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start got=%b exp=0", eng_start); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_cmp++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ack got=%b exp=0000", ack); end
    rst_n = 1'b1;
    eng_hang = 1'b0;
    stray = 0;
    repeat (10) begin @(negedge clk); if (ack !== 4'b0000) stray++; end
    n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL rst_mid_dropped got=%0d exp=0", stray); end
    req_data[7:0] = 8'h3C;
    req = 4'b0001;
    wait_ack(100, ok, a, res, id, err);
    req = '0;
    n_cmp++; if (!ok || id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_fresh_id got=%0d exp=0", id); end
    n_cmp++; if (res !== 8'd4) begin n_fail++; $display("FAIL rst_mid_fresh_result got=%0d exp=4", res); end
    wait_idle(ok);
  endtask

`ifdef POPCNT_SHARE_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int starts;
    do_reset();
    eng_hang = 1'b1;
    req_data[7:0] = 8'hFF;
    req = 4'b0001;
    ok = 1'b0;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin ok = 1'b1; break; end
      if (eng_start === 1'b1) starts++;
    end
    req = '0;
    n_cmp++; if (!ok || ack !== 4'b0001) begin n_fail++; $display("FAIL tmo_ack got=%b exp=0001", ack); end
    n_cmp++; if (starts != 32) begin n_fail++; $display("FAIL tmo_cycles got=%0d exp=32", starts); end
    n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got=%b exp=1", rsp_err); end
    n_cmp++; if (rsp_result !== 8'd0) begin n_fail++; $display("FAIL tmo_result got=%0d exp=0", rsp_result); end
    eng_hang = 1'b0;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL tmo_release got=busy exp=idle"); end
  endtask
`endif

  task automatic test_monitors();
    int exp_err;
`ifdef POPCNT_SHARE_TIMEOUT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    n_cmp++; if (mon_multi_hot != 0) begin n_fail++; $display("FAIL mon_one_hot got=%0d exp=0", mon_multi_hot); end
    n_cmp++; if (mon_long_ack != 0) begin n_fail++; $display("FAIL mon_single_cycle got=%0d exp=0", mon_long_ack); end
    n_cmp++; if (mon_early_gnt != 0) begin n_fail++; $display("FAIL mon_grant_while_done got=%0d exp=0", mon_early_gnt); end
    n_cmp++; if (mon_err_acks != exp_err) begin n_fail++; $display("FAIL mon_err_acks got=%0d exp=%0d", mon_err_acks, exp_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_back_to_back();
    test_withdraw();
    test_reset_mid();
`ifdef POPCNT_SHARE_TIMEOUT_EN
    test_timeout();
`endif
    test_monitors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
